// File: rtl/pu_riscv_ex_result.sv
// rtl/pu_riscv_ex_result.sv - execute-stage result collector with one-entry skid buffer
module pu_riscv_ex_result #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wb_stall,
   input  logic            ex_flush,
   input  logic            alu_bubble,
   input  logic [XLEN-1:0] alu_r,
   input  logic            mul_bubble,
   input  logic [XLEN-1:0] mul_r,
   input  logic            div_bubble,
   input  logic [XLEN-1:0] div_r,
   output logic            ex_bubble,
   output logic [XLEN-1:0] ex_r,
   output logic [1:0]      ex_src,
   output logic            ex_stall_req,
   output logic            err_collision,
   output logic            err_overflow
);

   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_ALU  = 2'd1;
   localparam logic [1:0] SRC_MUL  = 2'd2;
   localparam logic [1:0] SRC_DIV  = 2'd3;

   logic            in_vld;
   logic            in_coll;
   logic [XLEN-1:0] in_r;
   logic [1:0]      in_src;

   logic            skid_vld;
   logic [XLEN-1:0] skid_r;
   logic [1:0]      skid_src;

   // Pick the incoming result; the divider wins because its pulse cannot be repeated
   always_comb begin
      in_r   = '0;
      in_src = SRC_NONE;
      if (!div_bubble) begin
         in_r   = div_r;
         in_src = SRC_DIV;
      end else if (!mul_bubble) begin
         in_r   = mul_r;
         in_src = SRC_MUL;
      end else if (!alu_bubble) begin
         in_r   = alu_r;
         in_src = SRC_ALU;
      end
   end

   assign in_vld  = (in_src != SRC_NONE);
   assign in_coll = (!alu_bubble && !mul_bubble) || (!alu_bubble && !div_bubble) ||
                    (!mul_bubble && !div_bubble);

   // Stall request comes straight from the skid flag, never from inputs
   assign ex_stall_req = skid_vld;

   // Output register, skid register and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_bubble     <= 1'b1;
         ex_r          <= '0;
         ex_src        <= SRC_NONE;
         skid_vld      <= 1'b0;
         skid_r        <= '0;
         skid_src      <= SRC_NONE;
         err_collision <= 1'b0;
         err_overflow  <= 1'b0;
      end else if (ex_flush) begin
         ex_bubble <= 1'b1;
         ex_src    <= SRC_NONE;
         skid_vld  <= 1'b0;
      end else begin
         if (in_coll) begin
            err_collision <= 1'b1;
         end
         if (!wb_stall) begin
            if (skid_vld) begin
               // Drain the older skid entry first so results stay in order
               ex_bubble <= 1'b0;
               ex_r      <= skid_r;
               ex_src    <= skid_src;
               skid_vld  <= in_vld;
               if (in_vld) begin
                  skid_r   <= in_r;
                  skid_src <= in_src;
               end
            end else if (in_vld) begin
               ex_bubble <= 1'b0;
               ex_r      <= in_r;
               ex_src    <= in_src;
            end else begin
               ex_bubble <= 1'b1;
               ex_src    <= SRC_NONE;
            end
         end else if (in_vld) begin
            if (!skid_vld) begin
               skid_vld <= 1'b1;
               skid_r   <= in_r;
               skid_src <= in_src;
            end else begin
               err_overflow <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pu_riscv_ex_result.sv
// tb/tb_pu_riscv_ex_result.sv - self-checking bench for pu_riscv_ex_result
module tb_pu_riscv_ex_result;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wb_stall = 1'b0;
   logic        ex_flush = 1'b0;
   logic        alu_bubble = 1'b1;
   logic [63:0] alu_r = '0;
   logic        mul_bubble = 1'b1;
   logic [63:0] mul_r = '0;
   logic        div_bubble = 1'b1;
   logic [63:0] div_r = '0;
   logic        ex_bubble;
   logic [63:0] ex_r;
   logic [1:0]  ex_src;
   logic        ex_stall_req;
   logic        err_collision;
   logic        err_overflow;

   int n_cmp = 0;
   int n_bad = 0;

   pu_riscv_ex_result #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .wb_stall(wb_stall), .ex_flush(ex_flush),
      .alu_bubble(alu_bubble), .alu_r(alu_r),
      .mul_bubble(mul_bubble), .mul_r(mul_r),
      .div_bubble(div_bubble), .div_r(div_r),
      .ex_bubble(ex_bubble), .ex_r(ex_r), .ex_src(ex_src),
      .ex_stall_req(ex_stall_req),
      .err_collision(err_collision), .err_overflow(err_overflow)
   );

   always #5 clk = ~clk;

   // Reference model: two result slots (the one presented to write-back and a
   // waiting one) plus the sticky flags
   typedef struct {
      bit          v;
      logic [63:0] r;
      logic [1:0]  s;
   } slot_t;

   slot_t m_out, m_wait, m_new;
   bit    m_col, m_ovf, m_init = 0;
   logic [63:0] m_last_r;

   always @(posedge clk) begin
      int nv;
      m_new.v = 0; m_new.r = '0; m_new.s = 2'd0;
      if (!alu_bubble) begin m_new.v = 1; m_new.r = alu_r; m_new.s = 2'd1; end
      if (!mul_bubble) begin m_new.v = 1; m_new.r = mul_r; m_new.s = 2'd2; end
      if (!div_bubble) begin m_new.v = 1; m_new.r = div_r; m_new.s = 2'd3; end
      nv = int'(!alu_bubble) + int'(!mul_bubble) + int'(!div_bubble);
      if (rst) begin
         m_init = 1;
         m_out.v = 0; m_wait.v = 0; m_last_r = '0;
         m_col = 0; m_ovf = 0;
      end else if (ex_flush) begin
         m_out.v = 0; m_wait.v = 0;
      end else begin
         if (nv > 1) m_col = 1;
         if (!wb_stall) begin
            // write-back consumes; the oldest pending result moves up
            if (m_wait.v) begin
               m_out = m_wait;
               m_wait = m_new;
            end else begin
               m_out = m_new;
            end
            if (m_out.v) m_last_r = m_out.r;
         end else if (m_new.v) begin
            if (m_wait.v) m_ovf = 1;
            else m_wait = m_new;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the rising edge
   always @(negedge clk) begin
      if (m_init) begin
         chk("ex_bubble", 64'(ex_bubble), 64'(!m_out.v));
         chk("ex_r", ex_r, m_last_r);
         chk("ex_src", 64'(ex_src), m_out.v ? 64'(m_out.s) : 64'd0);
         chk("ex_stall_req", 64'(ex_stall_req), 64'(m_wait.v));
         chk("err_collision", 64'(err_collision), 64'(m_col));
         chk("err_overflow", 64'(err_overflow), 64'(m_ovf));
      end
   end

   // Drive one cycle of inputs, then return after the following falling edge
   task automatic cyc(input logic r, input logic st, input logic fl,
                      input logic ab, input logic [63:0] a,
                      input logic mb, input logic [63:0] m,
                      input logic db, input logic [63:0] d);
      #1;
      rst = r; wb_stall = st; ex_flush = fl;
      alu_bubble = ab; alu_r = a;
      mul_bubble = mb; mul_r = m;
      div_bubble = db; div_r = d;
      @(negedge clk);
   endtask

   task automatic idle(input logic st);
      cyc(0, st, 0, 1, 64'h0, 1, 64'h0, 1, 64'h0);
   endtask

   task automatic alu(input logic st, input logic [63:0] v);
      cyc(0, st, 0, 0, v, 1, 64'h0, 1, 64'h0);
   endtask

   task automatic mul(input logic st, input logic [63:0] v);
      cyc(0, st, 0, 1, 64'h0, 0, v, 1, 64'h0);
   endtask

   task automatic div(input logic st, input logic [63:0] v);
      cyc(0, st, 0, 1, 64'h0, 1, 64'h0, 0, v);
   endtask

   initial begin
      // reset state
      cyc(1, 0, 0, 1, 64'h0, 1, 64'h0, 1, 64'h0);
      chk("rst_bubble", 64'(ex_bubble), 64'd1);
      chk("rst_r", ex_r, 64'd0);
      chk("rst_src", 64'(ex_src), 64'd0);
      chk("rst_stall_req", 64'(ex_stall_req), 64'd0);

      // back-to-back
      alu(0, 64'h11);
      chk("b2b_r0", ex_r, 64'h11); chk("b2b_s0", 64'(ex_src), 64'd1);
      mul(0, 64'h22);
      chk("b2b_r1", ex_r, 64'h22); chk("b2b_s1", 64'(ex_src), 64'd2);
      div(0, 64'h33);
      chk("b2b_r2", ex_r, 64'h33); chk("b2b_s2", 64'(ex_src), 64'd3);
      chk("b2b_sr", 64'(ex_stall_req), 64'd0);
      idle(0);
      chk("b2b_idle_bubble", 64'(ex_bubble), 64'd1);
      chk("b2b_idle_hold", ex_r, 64'h33);

      // divider pulse under stall
      alu(0, 64'h5);
      div(1, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("dp_hold", ex_r, 64'h5);
      chk("dp_sr1", 64'(ex_stall_req), 64'd1);
      idle(0);
      chk("dp_r", ex_r, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("dp_src", 64'(ex_src), 64'd3);
      chk("dp_sr0", 64'(ex_stall_req), 64'd0);
      idle(0);

      // simultaneous release and arrival
      mul(1, 64'h7);
      chk("sim_sr", 64'(ex_stall_req), 64'd1);
      alu(0, 64'h8);
      chk("sim_r0", ex_r, 64'h7);
      chk("sim_sr_keep", 64'(ex_stall_req), 64'd1);
      idle(0);
      chk("sim_r1", ex_r, 64'h8);
      chk("sim_s1", 64'(ex_src), 64'd1);
      idle(0);

      // overflow
      alu(0, 64'hA);
      mul(1, 64'hB);
      div(1, 64'h9);
      chk("ovf_flag", 64'(err_overflow), 64'd1);
      chk("ovf_hold", ex_r, 64'hA);
      idle(0);
      chk("ovf_drain", ex_r, 64'hB);
      idle(0);
      chk("ovf_sticky", 64'(err_overflow), 64'd1);

      // collision
      cyc(0, 0, 0, 0, 64'h1, 1, 64'h0, 0, 64'h2);
      chk("col_r", ex_r, 64'h2);
      chk("col_src", 64'(ex_src), 64'd3);
      chk("col_flag", 64'(err_collision), 64'd1);
      idle(0);

      // flush mid-stall, then reset
      alu(0, 64'hC);
      mul(1, 64'hD);
      cyc(0, 1, 1, 1, 64'h0, 1, 64'h0, 1, 64'h0);
      chk("fl_bubble", 64'(ex_bubble), 64'd1);
      chk("fl_sr", 64'(ex_stall_req), 64'd0);
      chk("fl_col", 64'(err_collision), 64'd1);
      chk("fl_ovf", 64'(err_overflow), 64'd1);
      chk("fl_rhold", ex_r, 64'hC);
      cyc(1, 0, 0, 1, 64'h0, 1, 64'h0, 1, 64'h0);
      chk("rst2_r", ex_r, 64'd0);
      chk("rst2_col", 64'(err_collision), 64'd0);
      chk("rst2_ovf", 64'(err_overflow), 64'd0);

      // randomized traffic checked by the model
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 9) < 4),
             ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 2) != 0), {$urandom, $urandom},
             ($urandom_range(0, 3) != 0), {$urandom, $urandom},
             ($urandom_range(0, 4) != 0), {$urandom, $urandom});
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pu_riscv_ex_result.md
# pu_riscv_ex_result

Execute-stage result collector sitting directly downstream of the ALU, multiplier and divider units. Each cycle it takes the single valid (non-bubble) result among the three sources and registers it toward the memory/write-back stage. A one-entry skid buffer absorbs a result that arrives while write-back is stalled; this matters for the divider, which emits its result as a one-cycle pulse regardless of pipeline stall. Sticky error flags report protocol violations.

## Interface
- XLEN, 64, datapath width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- wb_stall  in  1  downstream cannot accept; output register must hold
- ex_flush  in  1  discard all held and incoming results
- alu_bubble  in  1  0 = alu_r valid this cycle
- alu_r  in  XLEN  ALU result
- mul_bubble  in  1  0 = mul_r valid this cycle
- mul_r  in  XLEN  multiplier result
- div_bubble  in  1  0 = div_r valid this cycle (single-cycle pulse)
- div_r  in  XLEN  divider result
- ex_bubble  out  1  0 = ex_r valid toward write-back
- ex_r  out  XLEN  registered result
- ex_src  out  2  source of ex_r: 0 none, 1 ALU, 2 MUL, 3 DIV
- ex_stall_req  out  1  skid buffer occupied; upstream must stop issuing
- err_collision  out  1  sticky: more than one source valid in the same cycle
- err_overflow  out  1  sticky: result arrived with skid full and wb_stall high; result lost

## Operation
- Incoming select: in_vld = any bubble low. Priority on collision is DIV > MUL > ALU. The lower-priority result is discarded and err_collision is set.
- State: output register (ex_bubble, ex_r, ex_src) plus skid register (skid_vld, skid_r, skid_src).
- Precedence per cycle: rst > ex_flush > wb_stall handling.
- rst: ex_bubble=1, ex_r=0, ex_src=0, skid_vld=0, skid_r=0, skid_src=0, err_collision=0, err_overflow=0.
- ex_flush: ex_bubble=1, ex_src=0, skid_vld=0. The incoming result is dropped. Error flags are unchanged; ex_r holds.
- wb_stall=0, skid empty: output register loads the incoming result. If none, ex_bubble=1 and ex_src=0, and ex_r holds.
- wb_stall=0, skid full: output register loads the skid contents. The skid loads the incoming result, with skid_vld=in_vld, so ordering is preserved.
- wb_stall=1: output register holds.
  - in_vld with skid empty: the skid captures the incoming result.
  - in_vld with skid full: the result is dropped and err_overflow is set.
- ex_stall_req = skid_vld, driven directly from the register (no combinational path from inputs).
- Error flags clear only on rst.

## Timing
- Latency: source bubble low in cycle N -> ex_bubble=0 in cycle N+1 (no stall, skid empty).
- Latency via skid: wb_stall deasserts in cycle M -> skid contents on the output in M+1.
- Throughput: one result per cycle when wb_stall=0.
- ex_stall_req rises the cycle after a capture into the skid. It falls the cycle after the skid drains with no new arrival.
- A result and wb_stall release in the same cycle with the skid full: the output takes the skid and the new result enters the skid; ex_stall_req stays 1.
- Reset or flush in the middle of a stall clears the skid in one cycle; nothing is replayed.

## Test plan
- Back-to-back results: ALU 0x11, MUL 0x22, DIV 0x33 on consecutive cycles, wb_stall=0 -> ex_r 0x11/0x22/0x33 on the next three cycles, ex_src 1/2/3, ex_stall_req=0.
- Divider pulse under stall:
  - Stimulus: wb_stall=1, output holding ALU 0x5; DIV 0xFFFF_FFFF_FFFF_FFFF arrives.
  - Response: skid captures it and ex_stall_req=1 next cycle.
  - Release stall: ex_r=0xFFFF_FFFF_FFFF_FFFF, ex_src=3, then ex_stall_req=0.
- Simultaneous release and arrival:
  - Stimulus: skid holds MUL 0x7; wb_stall drops in the same cycle ALU 0x8 arrives.
  - Response: ex_r=0x7, then ex_r=0x8 on the following cycle, order preserved.
- Overflow: wb_stall=1, skid full, DIV 0x9 arrives -> err_overflow=1 (sticky), 0x9 never appears on ex_r, held values unchanged.
- Collision: ALU 0x1 and DIV 0x2 valid in the same cycle -> ex_r=0x2, ex_src=3, err_collision=1 until rst.
- Flush and reset:
  - Stimulus: skid full, wb_stall=1, ex_flush=1.
  - Response: ex_bubble=1, ex_stall_req=0 next cycle, error flags unchanged.
  - Then rst=1: all outputs reach reset values at the next edge.
